// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared TLB constants, entry layout and page-select helper
package tlb_pkg;

  localparam int TLBNUM = 16;
  localparam int IDX_W  = 4;

  // r_data field offsets; CP0 unpacks TLBR data with these
  localparam int VPN2_HI = 77;
  localparam int VPN2_LO = 59;
  localparam int ASID_HI = 58;
  localparam int ASID_LO = 51;
  localparam int G_BIT   = 50;
  localparam int PFN0_HI = 49;
  localparam int PFN0_LO = 30;
  localparam int C0_HI   = 29;
  localparam int C0_LO   = 27;
  localparam int D0      = 26;
  localparam int V0      = 25;
  localparam int PFN1_HI = 24;
  localparam int PFN1_LO = 5;
  localparam int C1_HI   = 4;
  localparam int C1_LO   = 2;
  localparam int D1      = 1;
  localparam int V1      = 0;

  // EntryHi / EntryLo bit fields
  localparam int HI_VPN2_HI = 31;
  localparam int HI_VPN2_LO = 13;
  localparam int HI_ASID_HI = 7;
  localparam int HI_ASID_LO = 0;
  localparam int LO_PFN_HI  = 25;
  localparam int LO_PFN_LO  = 6;
  localparam int LO_C_HI    = 5;
  localparam int LO_C_LO    = 3;
  localparam int LO_D       = 2;
  localparam int LO_V       = 1;
  localparam int LO_G       = 0;

  // Field order matches the TLBR packing so an entry is r_data verbatim
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } tlb_page_t;

  function automatic tlb_page_t select_page(input tlb_entry_t e, input logic odd);
    tlb_page_t p;
    if (odd) p = '{pfn: e.pfn1, c: e.c1, d: e.d1, v: e.v1};
    else     p = '{pfn: e.pfn0, c: e.c0, d: e.d0, v: e.v0};
    return p;
  endfunction

endpackage

// File: rtl/tlb_match.sv
// rtl/tlb_match.sv - one search port: 16-way compare, lowest-index priority, page select
module tlb_match
  import tlb_pkg::*;
(
  input  logic                     en,
  input  tlb_entry_t [TLBNUM-1:0]  entries,
  input  logic [TLBNUM-1:0]        used,
  input  logic [18:0]              vpn2,
  input  logic                     odd_page,
  input  logic [7:0]               asid,
  output logic                     found,
  output logic [IDX_W-1:0]         index,
  output logic [19:0]              pfn,
  output logic [2:0]               c,
  output logic                     d,
  output logic                     v
);

  logic [TLBNUM-1:0] hit;
  tlb_page_t         page;

  // Per-entry match; en is dropped during reset so every search misses
  always_comb begin
    hit = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      hit[i] = en & used[i] & (entries[i].vpn2 == vpn2) &
               (entries[i].g | (entries[i].asid == asid));
    end
  end

  // Priority encode scanning downward so the lowest matching index is left standing
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (hit[i]) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

  // Select even/odd page of the winner; a miss forces every field to zero
  always_comb begin
    page = '0;
    if (found) page = select_page(entries[index], odd_page);
    pfn = page.pfn;
    c   = page.c;
    d   = page.d;
    v   = page.v;
  end

endmodule

// File: rtl/tlb.sv
// rtl/tlb.sv - 16-entry joint MIPS32 TLB: entry storage, TLBWI write, TLBR read, two search ports
module tlb
  import tlb_pkg::*;
#(
  parameter int TLBNUM_P = TLBNUM
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] s0_vpn2,
  input  logic        s0_odd_page,
  input  logic [7:0]  s0_asid,
  output logic        s0_found,
  output logic [3:0]  s0_index,
  output logic [19:0] s0_pfn,
  output logic [2:0]  s0_c,
  output logic        s0_d,
  output logic        s0_v,
  input  logic [18:0] s1_vpn2,
  input  logic        s1_odd_page,
  input  logic [7:0]  s1_asid,
  output logic        s1_found,
  output logic [3:0]  s1_index,
  output logic [19:0] s1_pfn,
  output logic [2:0]  s1_c,
  output logic        s1_d,
  output logic        s1_v,
  input  logic        we,
  input  logic [3:0]  w_index,
  input  logic [31:0] w_entryhi,
  input  logic [31:0] w_entrylo0,
  input  logic [31:0] w_entrylo1,
  input  logic [3:0]  r_index,
  output logic [77:0] r_data
);

  tlb_entry_t [TLBNUM-1:0] entries;
  logic [TLBNUM-1:0]       used;
  tlb_entry_t              new_entry;

  // EntryHi[12:8] and the upper EntryLo bits are architecturally unused here
  logic unused_bits;
  assign unused_bits = ^{w_entryhi[12:8], w_entrylo0[31:26], w_entrylo1[31:26]};

  // Unpack the CP0 registers into one entry; G is only global if both halves say so
  always_comb begin
    new_entry      = '0;
    new_entry.vpn2 = w_entryhi[HI_VPN2_HI:HI_VPN2_LO];
    new_entry.asid = w_entryhi[HI_ASID_HI:HI_ASID_LO];
    new_entry.g    = w_entrylo0[LO_G] & w_entrylo1[LO_G];
    new_entry.pfn0 = w_entrylo0[LO_PFN_HI:LO_PFN_LO];
    new_entry.c0   = w_entrylo0[LO_C_HI:LO_C_LO];
    new_entry.d0   = w_entrylo0[LO_D];
    new_entry.v0   = w_entrylo0[LO_V];
    new_entry.pfn1 = w_entrylo1[LO_PFN_HI:LO_PFN_LO];
    new_entry.c1   = w_entrylo1[LO_C_HI:LO_C_LO];
    new_entry.d1   = w_entrylo1[LO_D];
    new_entry.v1   = w_entrylo1[LO_V];
  end

  // Entry array: reset clears everything and beats a simultaneous TLBWI
  always_ff @(posedge clk) begin
    if (reset) begin
      entries <= '0;
      used    <= '0;
    end else if (we) begin
      entries[w_index] <= new_entry;
      used[w_index]    <= 1'b1;
    end
  end

  // TLBR read straight from the array, blanked while reset is held
  always_comb begin
    r_data = '0;
    if (!reset) r_data = entries[r_index];
  end

  tlb_match u_match_s0 (
    .en       (~reset),
    .entries  (entries),
    .used     (used),
    .vpn2     (s0_vpn2),
    .odd_page (s0_odd_page),
    .asid     (s0_asid),
    .found    (s0_found),
    .index    (s0_index),
    .pfn      (s0_pfn),
    .c        (s0_c),
    .d        (s0_d),
    .v        (s0_v)
  );

  tlb_match u_match_s1 (
    .en       (~reset),
    .entries  (entries),
    .used     (used),
    .vpn2     (s1_vpn2),
    .odd_page (s1_odd_page),
    .asid     (s1_asid),
    .found    (s1_found),
    .index    (s1_index),
    .pfn      (s1_pfn),
    .c        (s1_c),
    .d        (s1_d),
    .v        (s1_v)
  );

endmodule

// File: tb/tb_tlb.sv
// tb/tb_tlb.sv - directed self-checking bench for the tlb block
module tb_tlb;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] s0_vpn2, s1_vpn2;
  logic        s0_odd_page, s1_odd_page;
  logic [7:0]  s0_asid, s1_asid;
  logic        s0_found, s1_found;
  logic [3:0]  s0_index, s1_index;
  logic [19:0] s0_pfn, s1_pfn;
  logic [2:0]  s0_c, s1_c;
  logic        s0_d, s1_d, s0_v, s1_v;
  logic        we;
  logic [3:0]  w_index, r_index;
  logic [31:0] w_entryhi, w_entrylo0, w_entrylo1;
  logic [77:0] r_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tlb dut (
    .clk(clk), .reset(reset),
    .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
    .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
    .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .we(we), .w_index(w_index), .w_entryhi(w_entryhi),
    .w_entrylo0(w_entrylo0), .w_entrylo1(w_entrylo1),
    .r_index(r_index), .r_data(r_data)
  );

  // {found, index, pfn, c, d, v}
  wire [29:0] s0_res = {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v};
  wire [29:0] s1_res = {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v};

  task automatic check(input string tag, input logic [77:0] obs, input logic [77:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_entry(input logic [3:0] idx, input logic [31:0] hi,
                             input logic [31:0] lo0, input logic [31:0] lo1);
    @(negedge clk);
    we = 1'b1; w_index = idx; w_entryhi = hi; w_entrylo0 = lo0; w_entrylo1 = lo1;
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; w_index = '0; w_entryhi = '0; w_entrylo0 = '0; w_entrylo1 = '0;
    r_index = '0;
    s0_vpn2 = '0; s0_odd_page = 1'b0; s0_asid = '0;
    s1_vpn2 = '0; s1_odd_page = 1'b0; s1_asid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;

    // Reset state
    check("reset_s0_miss", 78'(s0_res), 78'd0);
    for (int i = 0; i < 16; i++) begin
      r_index = 4'(i);
      #1;
      check($sformatf("reset_rdata_%0d", i), r_data, 78'd0);
    end

    // Global entry at index 3 ignores ASID
    write_entry(4'd3, 32'h0040_2005, 32'h0000_0047, 32'h0000_0047);
    s1_vpn2 = 19'h00201; s1_asid = 8'h99; s1_odd_page = 1'b1;
    r_index = 4'd3;
    #1;
    check("idx3_global_hit", 78'(s1_res), 78'({1'b1, 4'd3, 20'd1, 3'd0, 1'b1, 1'b1}));
    check("idx3_rdata_g", 78'(r_data[50]), 78'd1);
    check("idx3_rdata", r_data, {19'h00201, 8'h05, 1'b1, 20'd1, 3'd0, 1'b1, 1'b1,
                                 20'd1, 3'd0, 1'b1, 1'b1});

    // Both ports hit the same entry concurrently
    s0_vpn2 = 19'h00201; s0_asid = 8'h42; s0_odd_page = 1'b0;
    #1;
    check("idx3_s0_concurrent", 78'(s0_res), 78'({1'b1, 4'd3, 20'd1, 3'd0, 1'b1, 1'b1}));

    // Non-global entry at index 5 with distinct even/odd pages
    write_entry(4'd5, 32'h1234_6011, 32'h0000_0106, 32'h0000_0158);
    s1_vpn2 = 19'h091A3; s1_asid = 8'h11; s1_odd_page = 1'b0;
    r_index = 4'd5;
    #1;
    check("idx5_even_hit", 78'(s1_res), 78'({1'b1, 4'd5, 20'd4, 3'd0, 1'b1, 1'b1}));
    check("idx5_rdata", r_data, {19'h091A3, 8'h11, 1'b0, 20'd4, 3'd0, 1'b1, 1'b1,
                                 20'd5, 3'd3, 1'b0, 1'b0});
    s1_odd_page = 1'b1;
    #1;
    check("idx5_odd_hit", 78'(s1_res), 78'({1'b1, 4'd5, 20'd5, 3'd3, 1'b0, 1'b0}));
    s1_asid = 8'h12;
    #1;
    check("idx5_asid_miss", 78'(s1_res), 78'd0);

    // Duplicate VPN2/ASID at 9 and 2: lowest index wins
    write_entry(4'd9, 32'hABCD_E0AA, 32'h0000_0282, 32'h0000_0000);
    write_entry(4'd2, 32'hABCD_E0AA, 32'h0000_0302, 32'h0000_0000);
    s1_vpn2 = 19'h55E6F; s1_asid = 8'hAA; s1_odd_page = 1'b0;
    #1;
    check("dup_lowest_wins", 78'(s1_res), 78'({1'b1, 4'd2, 20'hC, 3'd0, 1'b0, 1'b1}));

    // Write index 7 while s0 searches it: old contents this cycle, new next cycle
    @(negedge clk);
    we = 1'b1; w_index = 4'd7; w_entryhi = 32'h7700_0033;
    w_entrylo0 = 32'h0000_0046; w_entrylo1 = 32'h0000_0000;
    s0_vpn2 = 19'h3B800; s0_asid = 8'h33; s0_odd_page = 1'b0;
    #1;
    check("idx7_write_cycle_miss", 78'(s0_res), 78'd0);
    @(negedge clk);
    we = 1'b0;
    #1;
    check("idx7_next_cycle_hit", 78'(s0_res), 78'({1'b1, 4'd7, 20'd1, 3'd0, 1'b1, 1'b1}));

    // Last write to an index wins
    write_entry(4'd7, 32'h7700_0033, 32'h0000_0086, 32'h0000_0000);
    #1;
    check("idx7_rewrite", 78'(s0_res), 78'({1'b1, 4'd7, 20'd2, 3'd0, 1'b1, 1'b1}));

    // Reset together with a write to index 1
    @(negedge clk);
    reset = 1'b1; we = 1'b1; w_index = 4'd1; w_entryhi = 32'h0000_2001;
    w_entrylo0 = 32'h0000_0047; w_entrylo1 = 32'h0000_0047;
    s1_vpn2 = 19'h00201; s1_asid = 8'h99; s1_odd_page = 1'b0;
    r_index = 4'd3;
    #1;
    check("reset_cycle_s1_miss", 78'(s1_res), 78'd0);
    check("reset_cycle_rdata", r_data, 78'd0);
    @(negedge clk);
    reset = 1'b0; we = 1'b0;
    s0_vpn2 = 19'h00001; s0_asid = 8'h01; s0_odd_page = 1'b0;
    r_index = 4'd1;
    #1;
    check("reset_we_idx1_rdata", r_data, 78'd0);
    check("reset_we_idx1_miss", 78'(s0_res), 78'd0);
    check("post_reset_idx3_miss", 78'(s1_res), 78'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlb.md
# tlb

Joint 16-entry MIPS32 TLB for the perf-test CPU. It sits directly downstream of CP0 and consumes CP0's EntryHi, EntryLo0, EntryLo1 and Index registers on TLBWI. It returns a packed 78-bit entry to CP0 on TLBR, and a hit/index result to CP0 on TLBP. Two combinational search ports serve instruction fetch (s0) and data access / TLBP (s1) from the same registered entry array.

## Interface
Parameters:
- TLBNUM, 16, entry count; fixed at 16 because the CP0 Index field is 4 bits.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- s0_vpn2  in  19  fetch VA[31:13].
- s0_odd_page  in  1  fetch VA[12].
- s0_asid  in  8  current ASID (EntryHi[7:0]).
- s0_found  out  1  hit.
- s0_index  out  4  hit index.
- s0_pfn  out  20  selected PFN.
- s0_c  out  3  selected cache attribute.
- s0_d  out  1  selected dirty bit.
- s0_v  out  1  selected valid bit.
- s1_vpn2, s1_odd_page, s1_asid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v: same as s0, data side and TLBP.
- we  in  1  TLBWI commit, from WB.
- w_index  in  4  Index[3:0].
- w_entryhi  in  32  CP0 EntryHi.
- w_entrylo0  in  32  CP0 EntryLo0.
- w_entrylo1  in  32  CP0 EntryLo1.
- r_index  in  4  Index[3:0] for TLBR.
- r_data  out  78  packed entry for TLBR.

## Operation
- Per entry, store: vpn2[18:0], asid[7:0], g, pfn0[19:0], c0[2:0], d0, v0, pfn1[19:0], c1[2:0], d1, v1, plus an internal `used` bit.
- Write: on a cycle with we=1, entry[w_index] takes:
  - vpn2 = entryhi[31:13], asid = entryhi[7:0];
  - g = entrylo0[0] & entrylo1[0];
  - pfn0 = lo0[25:6], c0 = lo0[5:3], d0 = lo0[2], v0 = lo0[1];
  - the same fields from lo1 for the odd page;
  - used = 1.
- Match for entry i on port n: used_i & (vpn2_i == sn_vpn2) & (g_i | asid_i == sn_asid).
- Multiple matches: the lowest index wins. found = OR of all matches.
- Page select: odd_page=0 selects the pfn0/c0/d0/v0 fields; odd_page=1 selects the pfn1/c1/d1/v1 fields.
- Miss: found=0, and index, pfn, c, d and v are all 0.
- Read: r_data = {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1}. Bit fields are [77:59], [58:51], [50], [49:30], [29:27], [26], [25], [24:5], [4:2], [1], [0]. The value is combinational from the array. CP0 loads g into both G0 and G1.
- TLBP: driven by the pipeline through s1 with EntryHi. CP0 takes index_write_p = ~s1_found and index_write_index = s1_index.
- No exception generation in this block. Consumers decode refill (found=0), invalid (v=0) and modified (store & d=0).

## Timing
- Searches and reads: zero latency, purely combinational from the registered array.
- Writes: visible at the clock edge. A search or read of w_index in the write cycle returns the old contents; from the next cycle it returns the new contents.
- Reset: all `used` bits and all stored fields clear to 0 in one cycle. During the reset cycle and after it:
  - every search misses (outputs all 0);
  - r_data = 0 for any index.
- we asserted in the same cycle as reset: reset wins and the entry stays clear.
- Repeated writes to the same index: the last write wins. No wrap or ordering state beyond that.
- Both search ports may hit the same entry in the same cycle; they are independent.

## Structure
- Shared package/header: TLBNUM, the r_data field offsets (VPN2_HI=77 … V1=0), and the EntryHi/EntryLo bit-field constants. CP0 uses the same constants for its TLBR unpacking.
- One sub-module is natural: `tlb_match`. It is instantiated once per search port and does the 16-way compare, priority encode and odd/even select. The storage array and write/read logic live in `tlb`.

## Test plan
- Reset, then search s0 with vpn2=0, asid=0 -> s0_found=0; r_data for every index = 0.
- Write index 3 with hi=0x0040_2005 and lo0 = lo1 = 0x0000_0047 (PFN=1, C=0, D=1, V=1, G=1 on both). Then search s1 with vpn2=0x00201, asid=0x99, odd=1 -> found=1, index=3, pfn=1, c=0, d=1, v=1; r_index=3 gives g=1.
- Write index 5 with hi=0x1234_6011 and G=0. Search with asid 0x11 -> hit at index 5. Search with asid 0x12 -> miss.
- Write the same VPN2/ASID to indices 9 and 2, then search -> index=2.
- Assert we to index 7 while s0 searches that VPN -> miss in the write cycle, hit in the next cycle.
- Assert reset together with we to index 1 -> entry 1 remains clear and searches miss.
